// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_pkg
// Purpose  : Shared types and constants for the frame loader slice.
//            Provides the loader state enum, the word packing width and the
//            RAM word-address width.
// Ports    : none (package)
// Options  : FRAME_LOADER_CHECKSUM_EN adds the CHECK state to the enum.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_W         = 10;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

`ifdef FRAME_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TOP    = 3'd1,
        ST_BOTTOM = 3'd2,
        ST_DONE   = 3'd3,
        ST_CHECK  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TOP    = 2'd1,
        ST_BOTTOM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Purpose  : Collects accepted bytes into little-endian 32-bit words. The
//            first three bytes are held in a register; the word is presented
//            combinationally together with word_valid in the cycle the fourth
//            byte is accepted, so the caller registers it at that edge.
// Ports    : clk, reset (async, active-high)
//            clear      - drop any partial word, restart at byte index 0
//            accept     - byte_in is being taken this cycle
//            byte_in    - data byte
//            word       - {byte_in, byte2, byte1, byte0}
//            word_valid - fourth byte of a word accepted this cycle
// Revision : 1.0 - initial release
// ============================================================================
module byte_packer
    import matrix_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0] r_idx;
    logic [23:0]      r_bytes;

    // Only the index needs clearing; stale byte lanes are always overwritten
    // before they can reach a completed word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_bytes <= '0;
        end else if (clear) begin
            r_idx   <= '0;
        end else if (accept) begin
            r_idx <= (r_idx == C_LAST_IDX) ? '0 : r_idx + 1'b1;
            case (r_idx)
                2'd0:    r_bytes[7:0]   <= byte_in;
                2'd1:    r_bytes[15:8]  <= byte_in;
                2'd2:    r_bytes[23:16] <= byte_in;
                default: ;
            endcase
        end
    end

    assign word       = {byte_in, r_bytes};
    assign word_valid = accept && !clear && (r_idx == C_LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : frame_loader
// Purpose  : Loads a byte stream into two RAM halves. After sof, bytes are
//            packed into 32-bit words and written to RAM_Top addresses
//            0..WORDS_PER_HALF-1, then to RAM_Bottom over the same range,
//            after which frame_done pulses for one cycle. A sof inside a
//            frame aborts it and restarts at the top half.
// Params   : WORDS_PER_HALF - words per RAM half (1..1024)
// Ports    : clk, reset (async, active-high)
//            sof, byte_in[7:0], byte_valid / byte_ready - input stream
//            top_data_in[31:0], top_write_addr[9:0], top_write_enable
//            bottom_data_in[31:0], bottom_write_addr[9:0], bottom_write_enable
//            frame_done - one-cycle completion pulse
//            busy       - high outside IDLE
//            checksum_err - (FRAME_LOADER_CHECKSUM_EN only) XOR of frame
//                           bytes differs from the trailer byte
// Options  : FRAME_LOADER_CHECKSUM_EN - adds CHECK state, trailer byte and
//            checksum_err output.
// Revision : 1.0 - initial release
// ============================================================================
module frame_loader
    import matrix_pkg::*;
#(
    parameter int WORDS_PER_HALF = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sof,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [31:0]       top_data_in,
    output logic [ADDR_W-1:0] top_write_addr,
    output logic              top_write_enable,
    output logic [31:0]       bottom_data_in,
    output logic [ADDR_W-1:0] bottom_write_addr,
    output logic              bottom_write_enable,
    output logic              frame_done,
    output logic              busy
`ifdef FRAME_LOADER_CHECKSUM_EN
    ,
    output logic              checksum_err
`endif
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(WORDS_PER_HALF - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic              w_in_frame;
    logic              w_accept;
    logic              w_pack_accept;
    logic              w_last_word;
    logic [31:0]       w_word;
    logic              w_word_valid;

    // sof wins over a byte offered in the same cycle: that byte is dropped.
    assign w_in_frame    = (r_state == ST_TOP) || (r_state == ST_BOTTOM);
    assign w_accept      = byte_valid && byte_ready && !sof;
    assign w_pack_accept = w_accept && w_in_frame;
    assign w_last_word   = (r_addr == C_LAST_ADDR);

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (sof),
        .accept     (w_pack_accept),
        .byte_in    (byte_in),
        .word       (w_word),
        .word_valid (w_word_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        byte_ready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sof) w_state_next = ST_TOP;
            end
            ST_TOP: begin
                byte_ready = 1'b1;
                if (sof)                              w_state_next = ST_TOP;
                else if (w_word_valid && w_last_word) w_state_next = ST_BOTTOM;
            end
            ST_BOTTOM: begin
                byte_ready = 1'b1;
                if (sof) begin
                    w_state_next = ST_TOP;
                end else if (w_word_valid && w_last_word) begin
`ifdef FRAME_LOADER_CHECKSUM_EN
                    w_state_next = ST_CHECK;
`else
                    w_state_next = ST_DONE;
`endif
                end
            end
`ifdef FRAME_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                byte_ready = 1'b1;
                if (sof)           w_state_next = ST_TOP;
                else if (w_accept) w_state_next = ST_DONE;
            end
`endif
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign frame_done = (r_state == ST_DONE);
    assign busy       = (r_state != ST_IDLE);

    // Write port registers: data and address are captured at the edge that
    // accepts the fourth byte, so they are stable during the one-cycle strobe.
    // The half is chosen from the state at that edge, which keeps the final
    // top word in the top RAM even though the state moves on at the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr              <= '0;
            top_data_in         <= '0;
            top_write_addr      <= '0;
            top_write_enable    <= 1'b0;
            bottom_data_in      <= '0;
            bottom_write_addr   <= '0;
            bottom_write_enable <= 1'b0;
        end else begin
            top_write_enable    <= 1'b0;
            bottom_write_enable <= 1'b0;
            if (sof) begin
                r_addr <= '0;
            end else if (w_word_valid) begin
                if (r_state == ST_TOP) begin
                    top_data_in      <= w_word;
                    top_write_addr   <= r_addr;
                    top_write_enable <= 1'b1;
                end else begin
                    bottom_data_in      <= w_word;
                    bottom_write_addr   <= r_addr;
                    bottom_write_enable <= 1'b1;
                end
                r_addr <= w_last_word ? '0 : r_addr + 1'b1;
            end
        end
    end

`ifdef FRAME_LOADER_CHECKSUM_EN
    logic [7:0] r_xor;

    // The trailer itself is not folded into the accumulator; it is compared
    // against it, and the verdict appears with frame_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xor        <= '0;
            checksum_err <= 1'b0;
        end else if (sof) begin
            r_xor        <= '0;
            checksum_err <= 1'b0;
        end else if (w_pack_accept) begin
            r_xor <= r_xor ^ byte_in;
        end else if ((r_state == ST_CHECK) && w_accept) begin
            checksum_err <= (r_xor != byte_in);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_loader
// Purpose  : Self-checking bench for frame_loader. Instances with
//            WORDS_PER_HALF = 2, 4 and 1024 (plus 1 when
//            FRAME_LOADER_CHECKSUM_EN is defined) share one input stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_loader;
    import matrix_pkg::*;

`ifdef FRAME_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
    localparam int NDUT = 4;
`else
    localparam bit CK = 1'b0;
    localparam int NDUT = 3;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sof = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_in = 8'h00;

    logic        rdy   [NDUT];
    logic [31:0] tdata [NDUT];
    logic [9:0]  taddr [NDUT];
    logic        twe   [NDUT];
    logic [31:0] bdata [NDUT];
    logic [9:0]  baddr [NDUT];
    logic        bwe   [NDUT];
    logic        fd    [NDUT];
    logic        bsy   [NDUT];
`ifdef FRAME_LOADER_CHECKSUM_EN
    logic        cerr  [NDUT];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int W = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 1024 : 1;
        frame_loader #(.WORDS_PER_HALF(W)) u_dut (
            .clk                 (clk),
            .reset               (reset),
            .sof                 (sof),
            .byte_in             (byte_in),
            .byte_valid          (byte_valid),
            .byte_ready          (rdy[g]),
            .top_data_in         (tdata[g]),
            .top_write_addr      (taddr[g]),
            .top_write_enable    (twe[g]),
            .bottom_data_in      (bdata[g]),
            .bottom_write_addr   (baddr[g]),
            .bottom_write_enable (bwe[g]),
            .frame_done          (fd[g]),
            .busy                (bsy[g])
`ifdef FRAME_LOADER_CHECKSUM_EN
            ,
            .checksum_err        (cerr[g])
`endif
        );
    end

    // ------------------------------------------------------------------
    // Monitor: counts writes / pulses per instance; cleared by reset.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        half;   // 0 = top, 1 = bottom
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         log0 [$];
    int          cyc;
    int          top_cnt [NDUT];
    int          bot_cnt [NDUT];
    int          fd_cnt  [NDUT];
    int          wide_cnt[NDUT];
    int          both_cnt[NDUT];
    int          last_bot_cyc[NDUT];
    int          last_fd_cyc [NDUT];
    logic [9:0]  top_last_addr[NDUT];
    logic [9:0]  bot_last_addr[NDUT];
    logic [31:0] top_last_data[NDUT];
    logic        prev_twe[NDUT];
    logic        prev_bwe[NDUT];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset) log0.delete();
        for (int g = 0; g < NDUT; g++) begin
            if (reset) begin
                top_cnt[g] <= 0; bot_cnt[g] <= 0; fd_cnt[g] <= 0;
                wide_cnt[g] <= 0; both_cnt[g] <= 0;
                last_bot_cyc[g] <= 0; last_fd_cyc[g] <= 0;
                top_last_addr[g] <= '0; bot_last_addr[g] <= '0; top_last_data[g] <= '0;
                prev_twe[g] <= 1'b0; prev_bwe[g] <= 1'b0;
            end else begin
                prev_twe[g] <= twe[g];
                prev_bwe[g] <= bwe[g];
                if (twe[g]) begin
                    top_cnt[g] <= top_cnt[g] + 1;
                    top_last_addr[g] <= taddr[g];
                    top_last_data[g] <= tdata[g];
                    if (g == 0) log0.push_back({1'b0, taddr[g], tdata[g]});
                end
                if (bwe[g]) begin
                    bot_cnt[g] <= bot_cnt[g] + 1;
                    bot_last_addr[g] <= baddr[g];
                    last_bot_cyc[g] <= cyc;
                    if (g == 0) log0.push_back({1'b1, baddr[g], bdata[g]});
                end
                if (fd[g]) begin
                    fd_cnt[g] <= fd_cnt[g] + 1;
                    last_fd_cyc[g] <= cyc;
                end
                if ((twe[g] && prev_twe[g]) || (bwe[g] && prev_bwe[g]))
                    wide_cnt[g] <= wide_cnt[g] + 1;
                if (twe[g] && bwe[g]) both_cnt[g] <= both_cnt[g] + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic [7:0] b);
        @(negedge clk);
        sof = s; byte_valid = v; byte_in = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; sof = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Trailer byte only exists in the checksum build.
    task automatic send_trailer(input logic [7:0] b);
`ifdef FRAME_LOADER_CHECKSUM_EN
        drive(1'b0, 1'b1, b);
`else
        b = b;
`endif
    endtask

    task automatic check_log(input int idx, input wr_t exp, input string name);
        if (log0.size() > idx) check(name, 64'(log0[idx]), 64'(exp));
        else check({name, "_missing"}, 64'(log0.size()), 64'(idx + 1));
    endtask

    typedef struct {
        logic        s;
        logic        v;
        logic [7:0]  b;
        logic        twe;
        logic        bwe;
        logic [9:0]  addr;
        logic [31:0] data;
        logic        fd;
        logic        rdy;
        logic        bsy;
    } vec_t;

    vec_t tbl[20];
    int   nv;
    wr_t  exp_std[4];

    initial begin
        // Standard frame of bytes 01..10 into WORDS_PER_HALF=2 halves.
        exp_std[0] = {1'b0, 10'd0, 32'h04030201};
        exp_std[1] = {1'b0, 10'd1, 32'h08070605};
        exp_std[2] = {1'b1, 10'd0, 32'h0C0B0A09};
        exp_std[3] = {1'b1, 10'd1, 32'h100F0E0D};

        // ---------------- reset state ----------------
        #2;
        check("rst_tdata", 64'(tdata[0]), 64'd0);
        check("rst_taddr", 64'(taddr[0]), 64'd0);
        check("rst_twe",   64'(twe[0]),   64'd0);
        check("rst_bdata", 64'(bdata[0]), 64'd0);
        check("rst_baddr", 64'(baddr[0]), 64'd0);
        check("rst_bwe",   64'(bwe[0]),   64'd0);
        check("rst_rdy",   64'(rdy[0]),   64'd0);
        check("rst_busy",  64'(bsy[0]),   64'd0);
        check("rst_fd",    64'(fd[0]),    64'd0);
        do_reset();

        // ---------------- table: continuous frame (WPH=2) ----------------
        nv = 0;
        tbl[nv++] = '{s:1'b1, v:1'b0, b:8'h00, twe:1'b0, bwe:1'b0, addr:10'd0,
                      data:32'd0, fd:1'b0, rdy:1'b1, bsy:1'b1};
        for (int k = 1; k <= 16; k++) begin
            int w;
            vec_t e;
            w = k / 4 - 1;
            e = '{s:1'b0, v:1'b1, b:8'(k), twe:1'b0, bwe:1'b0, addr:10'd0,
                  data:32'd0, fd:1'b0, rdy:1'b1, bsy:1'b1};
            if (k % 4 == 0) begin
                e.twe  = (w < 2);
                e.bwe  = (w >= 2);
                e.addr = 10'(w % 2);
                e.data = {8'(k), 8'(k - 1), 8'(k - 2), 8'(k - 3)};
            end
            if (k == 16 && !CK) begin
                e.fd = 1'b1; e.rdy = 1'b0;
            end
            tbl[nv++] = e;
        end
        if (CK)  // trailer 0x10 = XOR of 01..10
            tbl[nv++] = '{s:1'b0, v:1'b1, b:8'h10, twe:1'b0, bwe:1'b0, addr:10'd0,
                          data:32'd0, fd:1'b1, rdy:1'b0, bsy:1'b1};
        tbl[nv++] = '{s:1'b0, v:1'b0, b:8'h00, twe:1'b0, bwe:1'b0, addr:10'd0,
                      data:32'd0, fd:1'b0, rdy:1'b0, bsy:1'b0};

        drive(tbl[0].s, tbl[0].v, tbl[0].b);
        for (int i = 0; i < nv; i++) begin
            @(negedge clk);
            check($sformatf("v%0d_twe", i), 64'(twe[0]), 64'(tbl[i].twe));
            check($sformatf("v%0d_bwe", i), 64'(bwe[0]), 64'(tbl[i].bwe));
            check($sformatf("v%0d_fd",  i), 64'(fd[0]),  64'(tbl[i].fd));
            check($sformatf("v%0d_rdy", i), 64'(rdy[0]), 64'(tbl[i].rdy));
            check($sformatf("v%0d_bsy", i), 64'(bsy[0]), 64'(tbl[i].bsy));
            if (tbl[i].twe) begin
                check($sformatf("v%0d_taddr", i), 64'(taddr[0]), 64'(tbl[i].addr));
                check($sformatf("v%0d_tdata", i), 64'(tdata[0]), 64'(tbl[i].data));
            end
            if (tbl[i].bwe) begin
                check($sformatf("v%0d_baddr", i), 64'(baddr[0]), 64'(tbl[i].addr));
                check($sformatf("v%0d_bdata", i), 64'(bdata[0]), 64'(tbl[i].data));
            end
            if (i + 1 < nv) begin
                sof = tbl[i + 1].s; byte_valid = tbl[i + 1].v; byte_in = tbl[i + 1].b;
            end
        end
        idle(2);
        check("cont_nwrites", 64'(log0.size()), 64'd4);
        check("cont_fd_cnt",  64'(fd_cnt[0]),   64'd1);
        check("cont_wide",    64'(wide_cnt[0]), 64'd0);

        // ---------------- byte_valid toggling ----------------
        do_reset();
        drive(1'b1, 1'b0, 8'h00);
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, 1'b1, 8'(k));
            drive(1'b0, 1'b0, 8'hEE);
        end
        send_trailer(8'h10);
        idle(4);
        check("tog_nwrites", 64'(log0.size()), 64'd4);
        for (int i = 0; i < 4; i++) check_log(i, exp_std[i], $sformatf("tog_w%0d", i));
        check("tog_fd_cnt", 64'(fd_cnt[0]),   64'd1);
        check("tog_wide",   64'(wide_cnt[0]), 64'd0);
        check("tog_both",   64'(both_cnt[0]), 64'd0);

        // ---------------- sof abort after 6 bytes ----------------
        do_reset();
        drive(1'b1, 1'b0, 8'h00);
        for (int k = 1; k <= 6; k++) drive(1'b0, 1'b1, 8'(8'hA0 + k));
        drive(1'b1, 1'b1, 8'h55);   // same-cycle byte must be dropped
        for (int k = 1; k <= 16; k++) drive(1'b0, 1'b1, 8'(k));
        send_trailer(8'h10);
        idle(4);
        check("abort_nwrites", 64'(log0.size()), 64'd5);
        check_log(0, {1'b0, 10'd0, 32'hA4A3A2A1}, "abort_w0");
        for (int i = 0; i < 4; i++) check_log(i + 1, exp_std[i], $sformatf("abort_w%0d", i + 1));
        check("abort_fd_cnt", 64'(fd_cnt[0]),   64'd1);
        check("abort_both",   64'(both_cnt[0]), 64'd0);

        // ---------------- async reset mid-frame (WPH=4) ----------------
        do_reset();
        drive(1'b1, 1'b0, 8'h00);
        for (int k = 1; k <= 12; k++) drive(1'b0, 1'b1, 8'(k));
        @(negedge clk);
        byte_valid = 1'b0;
        check("rst4_pre_twe",   64'(twe[1]),   64'd1);
        check("rst4_pre_taddr", 64'(taddr[1]), 64'd2);
        check("rst4_pre_tdata", 64'(tdata[1]), 64'h0C0B0A09);
        #2 reset = 1'b1;
        #1;
        check("rst4_tdata", 64'(tdata[1]), 64'd0);
        check("rst4_taddr", 64'(taddr[1]), 64'd0);
        check("rst4_twe",   64'(twe[1]),   64'd0);
        check("rst4_bdata", 64'(bdata[1]), 64'd0);
        check("rst4_baddr", 64'(baddr[1]), 64'd0);
        check("rst4_bwe",   64'(bwe[1]),   64'd0);
        check("rst4_rdy",   64'(rdy[1]),   64'd0);
        check("rst4_bsy",   64'(bsy[1]),   64'd0);
        check("rst4_fd",    64'(fd[1]),    64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b1, 8'(8'h30 + k));
            @(posedge clk);
            #1;
            check($sformatf("rst4_post_rdy%0d", k), 64'(rdy[1]), 64'd0);
            check($sformatf("rst4_post_twe%0d", k), 64'(twe[1]), 64'd0);
        end
        idle(1);
        check("rst4_no_writes", 64'(top_cnt[1] + bot_cnt[1]), 64'd0);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        check("rst4_sof_rdy", 64'(rdy[1]), 64'd1);

        // ---------------- full frame (WPH=1024) ----------------
        do_reset();
        drive(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 8192; k++) drive(1'b0, 1'b1, 8'(k));
        send_trailer(8'h00);
        idle(4);
        check("big_top_cnt",   64'(top_cnt[2]),       64'd1024);
        check("big_top_last",  64'(top_last_addr[2]), 64'd1023);
        check("big_top_ldata", 64'(top_last_data[2]), 64'hFFFEFDFC);
        check("big_bot_cnt",   64'(bot_cnt[2]),       64'd1024);
        check("big_bot_last",  64'(bot_last_addr[2]), 64'd1023);
        check("big_fd_cnt",    64'(fd_cnt[2]),        64'd1);
        check("big_fd_after",
              64'((last_fd_cyc[2] >= last_bot_cyc[2]) && (last_fd_cyc[2] - last_bot_cyc[2] <= 2)),
              64'd1);
        check("big_wide", 64'(wide_cnt[2]), 64'd0);

`ifdef FRAME_LOADER_CHECKSUM_EN
        // ---------------- checksum (WPH=1) ----------------
        do_reset();
        for (int f = 0; f < 2; f++) begin
            drive(1'b1, 1'b0, 8'h00);
            for (int k = 0; k < 8; k++) drive(1'b0, 1'b1, 8'(1 << k));
            drive(1'b0, 1'b1, (f == 0) ? 8'hFF : 8'h00);
            @(negedge clk);
            byte_valid = 1'b0;
            check($sformatf("ck%0d_fd", f),  64'(fd[3]),   64'd1);
            check($sformatf("ck%0d_err", f), 64'(cerr[3]), 64'(f));
            idle(2);
        end
        idle(3);
        check("ck_err_held", 64'(cerr[3]), 64'd1);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        check("ck_err_clr", 64'(cerr[3]), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
